wb_register_file: RTL
=====================

# wb_register_file

Writeback-stage consumer of the MEM/WB pipeline register. It selects the load or non-load result, commits it to a 16-entry × 32-bit ARM register file, and serves three combinational read ports to decode with same-cycle write-through bypass. Writes targeting R15 are not stored. Instead they raise a registered PC-redirect pulse toward fetch. A retired-write counter supports debug and performance visibility.

## Interface
- BYPASS, 1, when 1 a same-cycle writeback to the addressed register is forwarded to the read ports; when 0 reads return stored contents only
- CNT_W, 16, width of the retired-write counter
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- wb_load_data  in  32  loaded memory data from MEM/WB
- wb_alu_data  in  32  non-load result from MEM/WB
- wb_rd  in  4  destination register number
- wb_load  in  1  1 = commit wb_load_data, 0 = commit wb_alu_data
- wb_rf_en  in  1  register-file write enable for this cycle
- pc_plus8  in  32  current PC+8, returned for any read of R15
- ra_addr, rb_addr, rc_addr  in  4 each  read addresses (Rn, Rm, store-data Rd)
- ra_data, rb_data, rc_data  out  32 each  combinational read data
- pc_redirect  out  1  registered one-cycle pulse: writeback wrote R15
- pc_target  out  32  redirect target, valid when pc_redirect=1
- retire_count  out  CNT_W  number of committed writes, including R15 writes

## Operation
- wb_data = wb_load ? wb_load_data : wb_alu_data (combinational).
- Commit rule at each posedge clk when reset=0 and wb_rf_en=1:
  - wb_rd in 0..14: regs[wb_rd] <= wb_data.
  - wb_rd = 15: regs unchanged; pc_redirect <= 1; pc_target <= {wb_data[31:2], 2'b00}.
  - retire_count <= retire_count + 1, wrapping from 2^CNT_W−1 to 0.
- When wb_rf_en=0 or wb_rd≠15, pc_redirect <= 0 and pc_target holds its value.
- wb_rf_en=0: no state change except pc_redirect <= 0. wb_rd, wb_load and data are don't-care.
- Read port x (each independent, purely combinational):
  - addr = 15: pc_plus8. This takes priority over bypass, even when writeback targets R15.
  - Otherwise, if BYPASS=1, wb_rf_en=1 and wb_rd=addr: wb_data.
  - Otherwise: regs[addr].
- Any read port may address the same register as another port; all return identical data.
- Reset (synchronous, takes priority over a simultaneous write):
  - regs[0..14] <= 0
  - pc_redirect <= 0
  - pc_target <= 0
  - retire_count <= 0
- During the reset cycle the read ports still follow the combinational rules, including bypass of the in-flight write, but that write is discarded.

## Timing
- Write latency: data presented at edge N is readable from the array after edge N. With BYPASS=1 it is also visible on the read ports during the cycle before edge N.
- pc_redirect asserts the cycle after the edge that committed an R15 write and lasts exactly one cycle per such write. Back-to-back R15 writes hold it high for consecutive cycles, and pc_target updates on each.
- retire_count updates on the same edge as the commit.
- No handshake and no backpressure: one write per cycle is always accepted.

## Test plan
- Reset then read: assert reset 1 cycle; ra/rb/rc = 0,7,14 → all read 0; pc_redirect=0; retire_count=0.
- Load vs ALU select:
  - Write R3 with wb_load=1, load=0xDEADBEEF, alu=0x11111111 → R3 reads 0xDEADBEEF next cycle.
  - Write R3 with wb_load=0, alu=0x12345678 → R3 reads 0x12345678.
  - retire_count = 2.
- Bypass: BYPASS=1, wb_rf_en=1, wb_rd=5, alu=0xCAFEF00D, ra_addr=5 → ra_data=0xCAFEF00D in the same cycle. With BYPASS=0 → old R5 value until after the edge.
- R15 write: wb_rd=15, alu=0x00001003 → the next cycle pc_redirect=1 and pc_target=0x00001000; the cycle after, pc_redirect=0. ra_addr=15 with pc_plus8=0x2008 → 0x2008 throughout; R0..R14 unchanged.
- Disabled write and reset collision:
  - wb_rf_en=0, wb_rd=2, data=0xFFFFFFFF → R2 unchanged and count unchanged.
  - Write R2=0xAAAA together with reset=1 → R2 reads 0 afterward; retire_count=0.
- Counter wrap: CNT_W=4; perform 17 enabled writes → retire_count=1.

Source files
------------

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - Writeback stage: result select, 16x32 ARM register file, R15 redirect, retire counter
module wb_register_file #(
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wb_load_data,
  input  logic [31:0]      wb_alu_data,
  input  logic [3:0]       wb_rd,
  input  logic             wb_load,
  input  logic             wb_rf_en,
  input  logic [31:0]      pc_plus8,
  input  logic [3:0]       ra_addr,
  input  logic [3:0]       rb_addr,
  input  logic [3:0]       rc_addr,
  output logic [31:0]      ra_data,
  output logic [31:0]      rb_data,
  output logic [31:0]      rc_data,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [CNT_W-1:0] retire_count
);

  localparam int NUM_REGS = 15;

  logic [31:0]      regs_q [NUM_REGS];
  logic [31:0]      regs_d [NUM_REGS];
  logic             pc_redirect_q, pc_redirect_d;
  logic [31:0]      pc_target_q, pc_target_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;

  logic [31:0] wb_data;
  logic        wb_to_pc;

  assign wb_data  = wb_load ? wb_load_data : wb_alu_data;
  assign wb_to_pc = wb_rf_en && (wb_rd == 4'd15);

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    pc_redirect_d  = 1'b0;
    pc_target_d    = pc_target_q;
    retire_count_d = retire_count_q;
    if (wb_rf_en) begin
      retire_count_d = retire_count_q + CNT_W'(1);
      if (wb_to_pc) begin
        // R15 is never stored; a write to it becomes a word-aligned redirect
        pc_redirect_d = 1'b1;
        pc_target_d   = {wb_data[31:2], 2'b00};
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wb_rd == 4'(i)) begin
            regs_d[i] = wb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pc_redirect_q  <= 1'b0;
      pc_target_q    <= '0;
      retire_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pc_redirect_q  <= pc_redirect_d;
      pc_target_q    <= pc_target_d;
      retire_count_q <= retire_count_d;
    end
  end

  logic [3:0]  rd_addr [3];
  logic [31:0] rd_data [3];

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;
  assign rd_addr[2] = rc_addr;

  // PC+8 wins over bypass so decode never sees an in-flight R15 value
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr[p] == 4'(i)) begin
          rd_data[p] = regs_q[i];
        end
      end
      if (rd_addr[p] == 4'd15) begin
        rd_data[p] = pc_plus8;
      end else if (BYPASS && wb_rf_en && (wb_rd == rd_addr[p])) begin
        rd_data[p] = wb_data;
      end
    end
  end

  assign ra_data      = rd_data[0];
  assign rb_data      = rd_data[1];
  assign rc_data      = rd_data[2];
  assign pc_redirect  = pc_redirect_q;
  assign pc_target    = pc_target_q;
  assign retire_count = retire_count_q;

endmodule
